// File: rtl/tx_dma_fetch.sv
// Transmit DMA fetch engine: pulls packet data from a host ring into the TX slot RAM via PCIe reads.
// Optional completion-length checking is enabled by defining TXFETCH_ERRCHK_EN.
module tx_dma_fetch #(
  parameter int MAX_DW = 32
) (
  input  logic        clk_125,
  input  logic        sys_rst_n,
  input  logic        dma_enable,
  input  logic        dma_load,
  input  logic [31:2] dma_addr_start,
  input  logic [21:2] dma_length,
  input  logic [21:2] host_wr_ptr,
  output logic [31:2] dma_addr_cur,
  output logic [17:0] rdreq_din,
  output logic        rdreq_wr_en,
  input  logic        rdreq_full,
  input  logic [17:0] cpl_din,
  input  logic        cpl_valid,
  output logic        cpl_ready,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_byte_en,
  output logic        mem_wr_en,
  output logic [13:0] mem_wr_ptr,
  input  logic [13:0] mem_rd_ptr,
  output logic        busy,
  output logic        err
);

  localparam int             LW       = $clog2(MAX_DW) + 1;
  localparam logic [19:0]    MAX_LEN  = 20'(MAX_DW);
  localparam logic [13:0]    MIN_FREE = 14'(2 * MAX_DW);
  localparam logic [LW:0]    IDX_ONE  = (LW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_REQ0, S_REQ1, S_REQ2, S_WAIT_CPL, S_COMMIT, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [19:0]   fetch_ptr, fetch_adv, pending, to_end, to_4k, len_calc;
  logic [20:0]   diff;
  logic [13:0]   free;
  logic [LW-1:0] req_len;
  logic [LW:0]   idx, word_cnt, last_idx;
  logic          load_pend, start_ok, last_word, bad_word, unused_bits;

  assign dma_addr_cur = dma_addr_start + 30'(fetch_ptr);
  assign mem_byte_en  = 2'b11;
  assign busy         = (state != S_IDLE) && (state != S_HALT);

  // Ring occupancy: a negative difference means the producer has wrapped past the ring end.
  assign diff      = {1'b0, host_wr_ptr} - {1'b0, fetch_ptr};
  assign pending   = diff[20] ? (diff[19:0] + dma_length) : diff[19:0];
  assign free      = mem_rd_ptr - mem_wr_ptr - 14'd1;
  assign start_ok  = dma_enable && (pending != 20'd0) && (free >= MIN_FREE);
  assign to_end    = dma_length - fetch_ptr;
  assign to_4k     = 20'd1024 - {10'd0, dma_addr_cur[11:2]};
  assign fetch_adv = fetch_ptr + 20'(req_len);

  assign word_cnt  = {req_len, 1'b0};
  assign last_idx  = word_cnt - IDX_ONE;
  assign last_word = (idx == last_idx);

`ifdef TXFETCH_ERRCHK_EN
  assign bad_word = cpl_din[17] ^ last_word;
`else
  assign bad_word = 1'b0;
`endif

  assign unused_bits = ^{cpl_din[17:16], len_calc[19:LW]};

  always_comb begin
    len_calc = MAX_LEN;
    if (pending < len_calc) len_calc = pending;
    if (to_end  < len_calc) len_calc = to_end;
    if (to_4k   < len_calc) len_calc = to_4k;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    rdreq_din   = '0;
    rdreq_wr_en = 1'b0;
    cpl_ready   = 1'b0;
    case (state)
      S_IDLE: if (start_ok && !dma_load) state_nxt = S_CALC;
      S_CALC: state_nxt = S_REQ0;
      S_REQ0: begin
        rdreq_din = {2'b01, 4'h0, 2'b00, 10'(req_len)};
        if (!rdreq_full) begin
          rdreq_wr_en = 1'b1;
          state_nxt   = S_REQ1;
        end
      end
      S_REQ1: begin
        rdreq_din = {2'b00, dma_addr_cur[31:16]};
        if (!rdreq_full) begin
          rdreq_wr_en = 1'b1;
          state_nxt   = S_REQ2;
        end
      end
      S_REQ2: begin
        rdreq_din = {2'b10, dma_addr_cur[15:2], 2'b00};
        if (!rdreq_full) begin
          rdreq_wr_en = 1'b1;
          state_nxt   = S_WAIT_CPL;
        end
      end
      S_WAIT_CPL: begin
        cpl_ready = 1'b1;
        if (cpl_valid) begin
          if (bad_word)       state_nxt = S_HALT;
          else if (last_word) state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      S_HALT:   if (dma_load) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      fetch_ptr  <= '0;
      req_len    <= '0;
      idx        <= '0;
      mem_wr_ptr <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wr_en  <= 1'b0;
      err        <= 1'b0;
      load_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE, S_HALT: if (dma_load) begin
          fetch_ptr <= '0;
          err       <= 1'b0;
        end
        S_CALC: begin
          req_len <= len_calc[LW-1:0];
          idx     <= '0;
        end
        S_WAIT_CPL: if (cpl_valid) begin
          if (bad_word) err <= 1'b1;
          else begin
            mem_wr_en <= 1'b1;
            mem_addr  <= mem_wr_ptr + 14'(idx);
            mem_din   <= cpl_din[15:0];
            idx       <= idx + IDX_ONE;
          end
        end
        S_COMMIT: begin
          mem_wr_ptr <= mem_wr_ptr + 14'(word_cnt);
          // A load seen during the transfer restarts the ring instead of advancing it.
          if (load_pend || dma_load)      fetch_ptr <= '0;
          else if (fetch_adv >= dma_length) fetch_ptr <= '0;
          else                            fetch_ptr <= fetch_adv;
        end
        default: ;
      endcase
      if (state == S_IDLE || state == S_HALT || state == S_COMMIT || state_nxt == S_HALT)
        load_pend <= 1'b0;
      else if (dma_load)
        load_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_dma_fetch.sv
// Scoreboard bench for tx_dma_fetch: directed ring scenarios, bench acts as command FIFO and TLP completer.
module tb_tx_dma_fetch;
  localparam int MAX_DW = 32;

  logic        clk_125 = 1'b0;
  logic        sys_rst_n, dma_enable, dma_load, rdreq_full, cpl_valid;
  logic [31:2] dma_addr_start, dma_addr_cur;
  logic [21:2] dma_length, host_wr_ptr;
  logic [17:0] rdreq_din, cpl_din;
  logic        rdreq_wr_en, cpl_ready, mem_wr_en, busy, err;
  logic [13:0] mem_addr, mem_wr_ptr, mem_rd_ptr;
  logic [15:0] mem_din;
  logic [1:0]  mem_byte_en;

  tx_dma_fetch #(.MAX_DW(MAX_DW)) dut (
    .clk_125(clk_125), .sys_rst_n(sys_rst_n), .dma_enable(dma_enable), .dma_load(dma_load),
    .dma_addr_start(dma_addr_start), .dma_length(dma_length), .host_wr_ptr(host_wr_ptr),
    .dma_addr_cur(dma_addr_cur), .rdreq_din(rdreq_din), .rdreq_wr_en(rdreq_wr_en),
    .rdreq_full(rdreq_full), .cpl_din(cpl_din), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_byte_en(mem_byte_en), .mem_wr_en(mem_wr_en),
    .mem_wr_ptr(mem_wr_ptr), .mem_rd_ptr(mem_rd_ptr), .busy(busy), .err(err)
  );

  always #4 clk_125 = ~clk_125;

  int          checks = 0;
  int          errors = 0;
  int          req_seen = 0;
  int          served_words = 0;
  logic [17:0] exp_req_q[$];
  logic [29:0] exp_wr_q[$];
  logic [29:0] start;
  logic [13:0] m_wr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every command word and every RAM write against the queued expectations.
  always @(negedge clk_125) begin
    if (sys_rst_n) begin
      if (rdreq_full) check("rdreq_held", 32'(rdreq_wr_en), 32'd0);
      if (rdreq_wr_en) begin
        req_seen++;
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdreq_unexpected: got 0x%0h with no request expected", rdreq_din);
        end else check("rdreq_din", 32'(rdreq_din), 32'(exp_req_q.pop_front()));
      end
      if (mem_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_wr_unexpected: got addr 0x%0h data 0x%0h", mem_addr, mem_din);
        end else check("mem_write", 32'({mem_addr, mem_din}), 32'(exp_wr_q.pop_front()));
      end
    end
  end

  task automatic expect_req(input int len, input logic [19:0] off, input int rid,
                            input int nwr, input bit commit);
    logic [31:0] ba;
    ba = {start + 30'(off), 2'b00};
    exp_req_q.push_back({2'b01, 4'h0, 2'b00, 10'(len)});
    exp_req_q.push_back({2'b00, ba[31:16]});
    exp_req_q.push_back({2'b10, ba[15:2], 2'b00});
    for (int i = 0; i < nwr; i++) exp_wr_q.push_back({m_wr + 14'(i), 8'(rid), 8'(i)});
    if (commit) m_wr = m_wr + 14'(2 * len);
  endtask

  task automatic wait_req(input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (req_seen >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_125); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rdreq_timeout: saw %0d words, required %0d", req_seen, target);
    end
  endtask

  task automatic serve(input int len, input int rid, input int bad_idx, input int nwords,
                       input bit bp, input bit midload);
    bit ok;
    served_words += 3;
    if (bp) begin
      wait_req(served_words - 2, ok);
      if (!ok) return;
      @(posedge clk_125); #1 rdreq_full = 1'b1;
      repeat (3) @(posedge clk_125);
      #1 rdreq_full = 1'b0;
    end
    wait_req(served_words, ok);
    if (!ok) return;
    if (midload) dma_enable = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      int t;
      t = 0;
      @(negedge clk_125);
      dma_load = midload && (i == len);
      while (!cpl_ready && t < 100) begin
        @(negedge clk_125);
        t++;
      end
      if (!cpl_ready) begin
        checks++; errors++;
        $display("FAIL cpl_ready_timeout: word %0d of request %0d not accepted", i, rid);
        cpl_valid = 1'b0;
        dma_load  = 1'b0;
        return;
      end
      cpl_din   = {(i == bad_idx) || (i == 2 * len - 1), 1'b0, 8'(rid), 8'(i)};
      cpl_valid = 1'b1;
    end
    @(negedge clk_125);
    cpl_valid = 1'b0;
    dma_load  = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk_125); dma_load = 1'b1;
    @(negedge clk_125); dma_load = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk_125);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    sys_rst_n = 1'b0; dma_enable = 1'b0; dma_load = 1'b0; rdreq_full = 1'b0;
    cpl_valid = 1'b0; cpl_din = '0; dma_addr_start = '0; dma_length = '0;
    host_wr_ptr = '0; mem_rd_ptr = '0;
    repeat (3) @(negedge clk_125);
    check("rst_rdreq_wr_en", 32'(rdreq_wr_en), 32'd0);
    check("rst_cpl_ready",   32'(cpl_ready),   32'd0);
    check("rst_mem_wr_en",   32'(mem_wr_en),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_err",         32'(err),         32'd0);
    check("rst_mem_wr_ptr",  32'(mem_wr_ptr),  32'd0);
    check("rst_addr_cur",    32'(dma_addr_cur), 32'd0);
    check("rst_rdreq_din",   32'(rdreq_din),   32'd0);
    check("rst_mem_addr",    32'(mem_addr),    32'd0);
    check("rst_mem_din",     32'(mem_din),     32'd0);
    check("rst_byte_en",     32'(mem_byte_en), 32'd3);
    sys_rst_n = 1'b1;

    // Basic fetch: 16 DW pending on a 0x400-DW ring.
    start = 30'h0010_0000; dma_addr_start = start; dma_length = 20'h400; host_wr_ptr = 20'h10;
    pulse_load();
    expect_req(16, 20'h0, 1, 32, 1'b1);
    dma_enable = 1'b1;
    serve(16, 1, -1, 32, 1'b0, 1'b0);
    settle();
    check("basic_wr_ptr", 32'(mem_wr_ptr), 32'h20);
    check("basic_addr_cur", 32'(dma_addr_cur), 32'(start + 30'h10));
    check("basic_idle", 32'(busy), 32'd0);

    // Ring wrap on a 0x40-DW ring: 32+24 to reach 0x38, then 8 to the end and 8 from the base.
    dma_enable = 1'b0; dma_length = 20'h40; host_wr_ptr = 20'h38;
    pulse_load();
    expect_req(32, 20'h00, 2, 64, 1'b1);
    expect_req(24, 20'h20, 3, 48, 1'b1);
    dma_enable = 1'b1;
    serve(32, 2, -1, 64, 1'b0, 1'b0);
    serve(24, 3, -1, 48, 1'b0, 1'b0);
    settle();
    check("wrap_addr_pre", 32'(dma_addr_cur), 32'(start + 30'h38));
    host_wr_ptr = 20'h8;
    expect_req(8, 20'h38, 4, 16, 1'b1);
    expect_req(8, 20'h00, 5, 16, 1'b1);
    serve(8, 4, -1, 16, 1'b0, 1'b0);
    serve(8, 5, -1, 16, 1'b0, 1'b0);
    settle();
    check("wrap_addr_post", 32'(dma_addr_cur), 32'(start + 30'h8));
    check("wrap_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));

    // 4 KB clip: base sits 16 DW below a 4 KB boundary.
    dma_enable = 1'b0; start = 30'h0010_03F0; dma_addr_start = start; host_wr_ptr = 20'h20;
    pulse_load();
    expect_req(16, 20'h00, 6, 32, 1'b1);
    expect_req(16, 20'h10, 7, 32, 1'b1);
    dma_enable = 1'b1;
    serve(16, 6, -1, 32, 1'b0, 1'b0);
    serve(16, 7, -1, 32, 1'b0, 1'b0);
    settle();
    check("clip_addr_cur", 32'(dma_addr_cur), 32'(start + 30'h20));

    // Back-pressure on the second command word.
    dma_enable = 1'b0; start = 30'h0020_0000; dma_addr_start = start; host_wr_ptr = 20'h4;
    pulse_load();
    expect_req(4, 20'h0, 8, 8, 1'b1);
    dma_enable = 1'b1;
    serve(4, 8, -1, 8, 1'b1, 1'b0);
    settle();
    check("bp_addr_cur", 32'(dma_addr_cur), 32'(start + 30'h4));
    check("bp_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));

    // Slot RAM full: 62 free halfwords blocks, 64 allows; issue latency is two cycles.
    dma_enable = 1'b0; host_wr_ptr = 20'h24; mem_rd_ptr = m_wr + 14'd63;
    dma_enable = 1'b1;
    repeat (20) @(negedge clk_125);
    #1;
    check("full_no_busy", 32'(busy), 32'd0);
    check("full_no_req", 32'(req_seen), 32'(served_words));
    expect_req(32, 20'h4, 9, 64, 1'b1);
    mem_rd_ptr = mem_rd_ptr + 14'd2;
    @(negedge clk_125); #1;
    check("lat_calc_busy", 32'(busy), 32'd1);
    check("lat_calc_no_wr", 32'(rdreq_wr_en), 32'd0);
    @(negedge clk_125); #1;
    check("lat_first_wr", 32'(rdreq_wr_en), 32'd1);
    serve(32, 9, -1, 64, 1'b0, 1'b0);
    settle();
    check("full_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));
    check("full_addr_cur", 32'(dma_addr_cur), 32'(start + 30'h24));

    // Completion whose bit17 arrives early on word 10.
    dma_enable = 1'b0; mem_rd_ptr = m_wr - 14'd1;
    pulse_load();
    host_wr_ptr = 20'h10;
`ifdef TXFETCH_ERRCHK_EN
    expect_req(16, 20'h0, 10, 10, 1'b0);
    dma_enable = 1'b1;
    serve(16, 10, 10, 11, 1'b0, 1'b0);
    settle();
    check("err_set", 32'(err), 32'd1);
    check("err_halt_idle", 32'(busy), 32'd0);
    check("err_no_ready", 32'(cpl_ready), 32'd0);
    check("err_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));
`else
    expect_req(16, 20'h0, 10, 32, 1'b1);
    dma_enable = 1'b1;
    serve(16, 10, 10, 32, 1'b0, 1'b0);
    settle();
    check("noerr_flag", 32'(err), 32'd0);
    check("noerr_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));
    check("noerr_addr_cur", 32'(dma_addr_cur), 32'(start + 30'h10));
`endif
    dma_enable = 1'b0;
    pulse_load();
    settle();
    check("load_clr_err", 32'(err), 32'd0);
    check("load_idle", 32'(busy), 32'd0);
    check("load_addr_cur", 32'(dma_addr_cur), 32'(start));
    expect_req(16, 20'h0, 11, 32, 1'b1);
    dma_enable = 1'b1;
    serve(16, 11, -1, 32, 1'b0, 1'b0);
    settle();
    check("recover_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));

    // Load while the completion is in flight: data still commits, fetch restarts at the base.
    dma_enable = 1'b0; host_wr_ptr = 20'h18;
    expect_req(8, 20'h10, 12, 16, 1'b1);
    dma_enable = 1'b1;
    serve(8, 12, -1, 16, 1'b0, 1'b1);
    settle();
    check("midload_addr_cur", 32'(dma_addr_cur), 32'(start));
    check("midload_wr_ptr", 32'(mem_wr_ptr), 32'(m_wr));
    check("midload_idle", 32'(busy), 32'd0);

    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
